// File: rtl/stage_reg_mc.sv
// Parametrised pipeline stage register with multi-cycle context loop-back, bubble retention and stall-protocol checking.
// Optional occupancy counters are enabled by defining STAGE_PERF_EN.
module stage_reg_mc #(
    parameter int unsigned       DATA_W      = 146,
    parameter int unsigned       CTX_W       = 64,
    parameter int unsigned       CNT_W       = 2,
    parameter int unsigned       STALL_W     = 6,
    parameter int unsigned       STAGE       = 3,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = {DATA_W{1'b0}},
    parameter logic [DATA_W-1:0] KEEP_MASK   = {DATA_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [STALL_W-1:0]  stall,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_payload,
    input  logic [CTX_W-1:0]    ctx_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_payload,
    output logic [CTX_W-1:0]    ctx_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic                err_o,
    output logic [31:0]         bubble_cnt,
    output logic [31:0]         hold_cnt
);

    localparam int unsigned US_IDX = STAGE;
    localparam int unsigned DS_IDX = STAGE + 32'd1;

    generate
        if (int'(STAGE) > int'(STALL_W) - 2) begin : g_stage_range_err
            $error("stage_reg_mc: STAGE must lie in 0..STALL_W-2");
        end
    endgenerate

    typedef enum logic [2:0] {
        MODE_FLUSH   = 3'd0,
        MODE_BUBBLE  = 3'd1,
        MODE_ADVANCE = 3'd2,
        MODE_HOLD    = 3'd3,
        MODE_ILLEGAL = 3'd4
    } mode_e;

    mode_e               mode_s;
    logic                us_s;
    logic                ds_s;
    logic [DATA_W-1:0]   bubble_payload_s;
    logic                stall_unused_s;

    logic                valid_r;
    logic [DATA_W-1:0]   payload_r;
    logic [CTX_W-1:0]    ctx_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                err_r;

    assign stall_unused_s = ^stall;

    // Decode the upstream/downstream stall pair into one update mode; flush has top priority.
    always_comb begin
        us_s             = stall[US_IDX];
        ds_s             = stall[DS_IDX];
        bubble_payload_s = (NOP_PAYLOAD & ~KEEP_MASK) | (payload_r & KEEP_MASK);
        if (clr) begin
            mode_s = MODE_FLUSH;
        end else if (us_s && !ds_s) begin
            mode_s = MODE_BUBBLE;
        end else if (!us_s && !ds_s) begin
            mode_s = MODE_ADVANCE;
        end else if (us_s && ds_s) begin
            mode_s = MODE_HOLD;
        end else begin
            mode_s = MODE_ILLEGAL;
        end
    end

    // Stage register: payload/valid toward S+1 and context looped back to S while S is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            payload_r <= NOP_PAYLOAD;
            ctx_r     <= {CTX_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            case (mode_s)
                MODE_FLUSH: begin
                    valid_r   <= 1'b0;
                    payload_r <= NOP_PAYLOAD;
                    ctx_r     <= {CTX_W{1'b0}};
                    cnt_r     <= {CNT_W{1'b0}};
                end
                MODE_BUBBLE: begin
                    valid_r   <= 1'b0;
                    payload_r <= bubble_payload_s;
                    ctx_r     <= ctx_i;
                    cnt_r     <= cnt_i;
                end
                MODE_ADVANCE: begin
                    valid_r   <= in_valid;
                    payload_r <= in_payload;
                    ctx_r     <= {CTX_W{1'b0}};
                    cnt_r     <= {CNT_W{1'b0}};
                end
                MODE_HOLD: begin
                    ctx_r <= ctx_i;
                    cnt_r <= cnt_i;
                end
                MODE_ILLEGAL: begin
                    ctx_r <= ctx_i;
                    cnt_r <= cnt_i;
                    err_r <= 1'b1;
                end
                default: begin
                    valid_r   <= valid_r;
                    payload_r <= payload_r;
                end
            endcase
        end
    end

    assign out_valid   = valid_r;
    assign out_payload = payload_r;
    assign ctx_o       = ctx_r;
    assign cnt_o       = cnt_r;
    assign err_o       = err_r;

`ifdef STAGE_PERF_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] hold_cnt_r;

    // Occupancy counters; only rst_n clears them, they wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= 32'd0;
            hold_cnt_r   <= 32'd0;
        end else begin
            if (mode_s == MODE_BUBBLE) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
            if ((mode_s == MODE_HOLD) || (mode_s == MODE_ILLEGAL)) begin
                hold_cnt_r <= hold_cnt_r + 32'd1;
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_r;
    assign hold_cnt   = hold_cnt_r;
`else
    assign bubble_cnt = 32'd0;
    assign hold_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_stage_reg_mc.sv
// Randomised scoreboard bench for stage_reg_mc: a behavioural model queues expected outputs, a monitor compares them.
module tb_stage_reg_mc;

    localparam int unsigned DW = 80;
    localparam logic [DW-1:0] NOP  = 80'h0000_1111_2222_0000_0003;
    localparam logic [DW-1:0] KEEP = 80'hFFFF_0000_0000_0000_00F0;

    logic            clk;
    logic            rst_n;
    logic            clr;
    logic [5:0]      stall;
    logic            in_valid;
    logic [DW-1:0]   in_payload;
    logic [63:0]     ctx_i;
    logic [1:0]      cnt_i;
    logic            out_valid;
    logic [DW-1:0]   out_payload;
    logic [63:0]     ctx_o;
    logic [1:0]      cnt_o;
    logic            err_o;
    logic [31:0]     bubble_cnt;
    logic [31:0]     hold_cnt;

    stage_reg_mc #(
        .DATA_W(DW), .CTX_W(64), .CNT_W(2), .STALL_W(6), .STAGE(3),
        .NOP_PAYLOAD(NOP), .KEEP_MASK(KEEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .stall(stall),
        .in_valid(in_valid), .in_payload(in_payload), .ctx_i(ctx_i), .cnt_i(cnt_i),
        .out_valid(out_valid), .out_payload(out_payload), .ctx_o(ctx_o), .cnt_o(cnt_o),
        .err_o(err_o), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] p;
        logic [63:0]   c;
        logic [1:0]    n;
        logic          e;
        logic [31:0]   b;
        logic [31:0]   h;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: what the stage should present after every edge.
    logic          m_v;
    logic [DW-1:0] m_p;
    logic [63:0]   m_c;
    logic [1:0]    m_n;
    logic          m_e;
    logic [31:0]   m_b;
    logic [31:0]   m_h;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 1'b0; m_p = NOP; m_c = 64'd0; m_n = 2'd0; m_e = 1'b0; m_b = 32'd0; m_h = 32'd0;
    endtask

    task automatic model_step(input logic c, input logic [5:0] st, input logic iv,
                              input logic [DW-1:0] ip, input logic [63:0] cx, input logic [1:0] cn);
        logic up, dn;
        up = st[3];
        dn = st[4];
        if (c) begin
            m_v = 1'b0; m_p = NOP; m_c = 64'd0; m_n = 2'd0;
        end else if (!dn) begin
            if (up) begin
                // Bubble: each kept bit retains its old value, the rest take the NOP pattern.
                for (int i = 0; i < int'(DW); i++) m_p[i] = KEEP[i] ? m_p[i] : NOP[i];
                m_v = 1'b0; m_c = cx; m_n = cn;
`ifdef STAGE_PERF_EN
                m_b = m_b + 32'd1;
`endif
            end else begin
                m_v = iv; m_p = ip; m_c = 64'd0; m_n = 2'd0;
            end
        end else begin
            m_c = cx; m_n = cn;
            if (!up) m_e = 1'b1;
`ifdef STAGE_PERF_EN
            m_h = m_h + 32'd1;
`endif
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected post-edge state.
    task automatic step(input logic c, input logic [5:0] st, input logic iv,
                        input logic [DW-1:0] ip, input logic [63:0] cx, input logic [1:0] cn);
        exp_t e;
        clr = c; stall = st; in_valid = iv; in_payload = ip; ctx_i = cx; cnt_i = cn;
        model_step(c, st, iv, ip, cx, cn);
        e.v = m_v; e.p = m_p; e.c = m_c; e.n = m_n; e.e = m_e; e.b = m_b; e.h = m_h;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rand_pl();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic logic [63:0] rand_ctx();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, {127'd0, out_valid}, 128'd0);
        chk({tag, "_payload"}, {48'd0, out_payload}, {48'd0, NOP});
        chk({tag, "_ctx"}, {64'd0, ctx_o}, 128'd0);
        chk({tag, "_cnt"}, {126'd0, cnt_o}, 128'd0);
        chk({tag, "_err"}, {127'd0, err_o}, 128'd0);
        chk({tag, "_bubble_cnt"}, {96'd0, bubble_cnt}, 128'd0);
        chk({tag, "_hold_cnt"}, {96'd0, hold_cnt}, 128'd0);
    endtask

    // Monitor: one expected record per clocked update, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_valid", {127'd0, out_valid}, {127'd0, e.v});
            chk("out_payload", {48'd0, out_payload}, {48'd0, e.p});
            chk("ctx_o", {64'd0, ctx_o}, {64'd0, e.c});
            chk("cnt_o", {126'd0, cnt_o}, {126'd0, e.n});
            chk("err_o", {127'd0, err_o}, {127'd0, e.e});
            chk("bubble_cnt", {96'd0, bubble_cnt}, {96'd0, e.b});
            chk("hold_cnt", {96'd0, hold_cnt}, {96'd0, e.h});
        end
    end

    initial begin
        logic [5:0] st;
        rst_n = 1'b0; clr = 1'b0; stall = 6'd0; in_valid = 1'b0;
        in_payload = {DW{1'b0}}; ctx_i = 64'd0; cnt_i = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Directed: advance, bubble with context, hold, flush priority, illegal stall.
        step(1'b0, 6'b000000, 1'b1, 80'hFFFF_0000_0000_0000_ABCD, rand_ctx(), 2'd3);
        step(1'b0, 6'b001000, 1'b1, rand_pl(), 64'h1234_5678_9ABC_DEF0, 2'b01);
        step(1'b0, 6'b000000, 1'b1, 80'h1234_5678_9ABC_DEF0_1357, 64'd0, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 6'b011000, 1'b0, rand_pl(), rand_ctx(), 2'($urandom_range(3)));
        step(1'b1, 6'b001000, 1'b1, rand_pl(), rand_ctx(), 2'd2);
        step(1'b1, 6'b010000, 1'b1, rand_pl(), rand_ctx(), 2'd2);
        step(1'b0, 6'b000000, 1'b1, rand_pl(), rand_ctx(), 2'd1);
        step(1'b0, 6'b010000, 1'b1, rand_pl(), rand_ctx(), 2'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 6'b000000, 1'b1, rand_pl(), rand_ctx(), 2'd0);

        // Asynchronous reset in the middle of a hold, checked before any clock edge.
        step(1'b0, 6'b011000, 1'b1, rand_pl(), rand_ctx(), 2'd3);
        clr = 1'b0; stall = 6'b011000; in_valid = 1'b1; in_payload = rand_pl(); ctx_i = rand_ctx(); cnt_i = 2'd2;
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic with periodic resets so the sticky error flag is exercised repeatedly.
        for (int k = 0; k < 600; k++) begin
            st = 6'($urandom());
            if ($urandom_range(3) != 0) st[4] = st[3] & st[4];
            step(($urandom_range(15) == 0) ? 1'b1 : 1'b0, st, 1'($urandom()), rand_pl(), rand_ctx(),
                 2'($urandom()));
            if ((k % 150) == 149) begin
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                check_reset_state("periodic_reset");
                rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/stage_reg_mc.md
Name: stage_reg_mc

Overview:
- Parametrised pipeline stage register for the MIPS core, the generalised successor of the fixed EX/MEM latch.
- Sits between upstream stage S and downstream stage S+1 and carries an arbitrary-width payload plus a valid bit.
- Carries a multi-cycle context channel (accumulator + step counter, e.g. madd/msub/div state) that loops back upstream while the upstream stage is stalled.
- Adds valid tracking, per-bit bubble retention, stall-protocol error detection and optional occupancy counters.

Parameters:
- DATA_W, 146, payload width (wd 5 + wreg 1 + wdata 32 + hi 32 + lo 32 + whilo 1 + aluop 8 + addr 32 + reg2 32 = 175 if packed fully; the integrator sets the actual value).
- CTX_W, 64, multi-cycle context width (hi:lo accumulator).
- CNT_W, 2, multi-cycle step counter width.
- STALL_W, 6, width of the global stall vector.
- STAGE, 3, index of the upstream stall bit; downstream bit is STAGE+1; legal range 0..STALL_W-2.
- NOP_PAYLOAD, all-zero, payload value loaded on bubble, clear or reset.
- KEEP_MASK, all-zero, payload bits set here keep their previous out_payload value on bubble (e.g. PC for exception reporting); clear and reset ignore it.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush (exception/branch kill), active high.
- stall  in  STALL_W  global stall vector; bit STAGE = upstream stalled, bit STAGE+1 = downstream stalled.
- in_valid  in  1  upstream slot holds a real instruction.
- in_payload  in  DATA_W  upstream result bundle.
- ctx_i  in  CTX_W  multi-cycle context from upstream.
- cnt_i  in  CNT_W  multi-cycle step from upstream.
- out_valid  out  1  registered valid.
- out_payload  out  DATA_W  registered bundle to downstream.
- ctx_o  out  CTX_W  context fed back to upstream.
- cnt_o  out  CNT_W  step fed back to upstream.
- err_o  out  1  sticky stall-protocol violation flag.
- bubble_cnt  out  32  bubbles inserted (STAGE_PERF_EN only).
- hold_cnt  out  32  cycles held (STAGE_PERF_EN only).

Behaviour:
- Let us = stall[STAGE] and ds = stall[STAGE+1].
- Reset (rst_n=0, asynchronous, dominates all else):
  - out_valid=0, out_payload=NOP_PAYLOAD, ctx_o=0, cnt_o=0, err_o=0, counters=0.
- Otherwise, on each rising clk edge, the first matching case applies:
  1. clr=1 (flush):
     - out_valid<=0, out_payload<=NOP_PAYLOAD, ctx_o<=0, cnt_o<=0.
     - err_o unchanged.
  2. us=1, ds=0 (bubble):
     - out_valid<=0.
     - out_payload<=(NOP_PAYLOAD & ~KEEP_MASK) | (out_payload & KEEP_MASK).
     - ctx_o<=ctx_i, cnt_o<=cnt_i.
  3. us=0, ds=0 (advance):
     - out_valid<=in_valid, out_payload<=in_payload.
     - ctx_o<=0, cnt_o<=0.
  4. us=1, ds=1 (hold):
     - out_valid and out_payload unchanged.
     - ctx_o<=ctx_i, cnt_o<=cnt_i.
  5. us=0, ds=1 (illegal: the stall controller must always stall upstream when downstream stalls):
     - Treated as hold; err_o<=1, sticky until reset.
- Latency: 1 cycle from in_* to out_*; ctx/cnt loop-back also 1 cycle.
- in_valid=0 during advance produces out_valid=0 but still loads in_payload unchanged, so downstream must qualify on out_valid.
- clr in the same cycle as any stall pattern: flush wins and err_o is not set.
- Reset deasserted asynchronously: first update occurs on the next clk edge.
- STAGE out of range is a compile-time error via a generate-time check.

Optional Feature:
- Macro STAGE_PERF_EN.
- Defined:
  - bubble_cnt increments by 1 on every case-2 cycle.
  - hold_cnt increments by 1 on every case-4 or case-5 cycle.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, are cleared only by rst_n, and are unaffected by clr.
- Undefined: ports remain, both driven constant 0, and no counter flops are inferred.

Test Plan:
- Reset then advance: rst_n 0->1, stall=0, in_valid=1, in_payload=0x..ABCD -> next cycle out_valid=1, out_payload=0x..ABCD, ctx_o=0, cnt_o=0.
- Bubble with context: STAGE=3, stall=6'b001000, ctx_i=0x1234_5678_9ABC_DEF0, cnt_i=2'b01 -> out_valid=0, payload=NOP except KEEP_MASK bits unchanged, ctx_o=ctx_i, cnt_o=1; bubble_cnt=1 if STAGE_PERF_EN.
- Hold: stall=6'b011000 for 3 cycles with changing in_payload -> out_payload and out_valid frozen, ctx_o/cnt_o track inputs each cycle, hold_cnt=3.
- Flush priority: clr=1 with stall=6'b001000 and in_valid=1 -> out_valid=0, payload=NOP_PAYLOAD (KEEP bits also cleared), ctx_o=0, cnt_o=0, err_o=0.
- Illegal stall: stall=6'b010000 -> outputs held, err_o=1, err_o remains 1 after stall returns to 0 until rst_n pulses low.
- Async reset mid-hold: rst_n=0 between clock edges -> all outputs zero immediately, without waiting for clk.
